// File: rtl/regfile_uart_dumper.sv
// Register file with two registered read ports plus a byte-stream dumper that
// emits full or dirty-only frames over a valid/ready link, closed by an XOR checksum.
module regfile_uart_dumper #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter logic [7:0]  HDR_ALL   = 8'hA5,
    parameter logic [7:0]  HDR_DIRTY = 8'h5A
) (
    input  logic                     clk12,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [$clog2(NREGS)-1:0] rd_addr0,
    input  logic [$clog2(NREGS)-1:0] rd_addr1,
    output logic [XLEN-1:0]          rd_data0,
    output logic [XLEN-1:0]          rd_data1,
    input  logic                     dump_req,
    input  logic                     dump_mode,
    output logic                     busy,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
);
    localparam int unsigned AW        = $clog2(NREGS);
    localparam int unsigned NBYTES    = XLEN / 8;
    localparam int unsigned BW        = $clog2(NBYTES + 1);
    localparam logic [AW:0]   NREGS_C   = (AW+1)'(NREGS);
    localparam logic [AW:0]   LAST_C    = (AW+1)'(NREGS - 1);
    localparam logic [BW-1:0] NBYTES_C  = BW'(NBYTES);
    localparam logic [BW-1:0] ONE_B     = BW'(1'b1);
    localparam logic [7:0]    TERM_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SCAN = 3'd2,
        ST_IDX  = 3'd3,
        ST_DATA = 3'd4,
        ST_TERM = 3'd5,
        ST_CSUM = 3'd6
    } state_t;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [XLEN-1:0] regs_r [NREGS];
    logic [NREGS-1:0] dirty_r, snap_r, wr_mask_s;
    logic [XLEN-1:0] rd0_r, rd1_r;
    state_t          state_r, state_nx;
    logic            mode_r;
    logic [7:0]      tx_data_r, tx_data_nx, csum_r, csum_nx;
    logic            tx_valid_r, tx_valid_nx, busy_r, busy_nx;
    logic [AW:0]     reg_idx_r, reg_idx_nx, idx_inc_s;
    logic [BW-1:0]   byte_idx_r, byte_idx_nx;
    logic [XLEN-1:0] shift_r, shift_nx, cur_word_s, next_word_s;
    logic            accept_s, xfer_s, wr_hit_s;

    assign wr_hit_s    = wr_en & (wr_addr != {AW{1'b0}});
    assign wr_mask_s   = {{(NREGS-1){1'b0}}, wr_hit_s} << wr_addr;
    assign xfer_s      = tx_valid_r & tx_ready;
    assign idx_inc_s   = reg_idx_r + {{AW{1'b0}}, 1'b1};
    assign cur_word_s  = regs_r[reg_idx_r[AW-1:0]];
    assign next_word_s = regs_r[idx_inc_s[AW-1:0]];

    assign rd_data0 = rd0_r;
    assign rd_data1 = rd1_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;

    // Register array and live dirty bits; a write in the accept cycle survives the clear
    always_ff @(posedge clk12) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            dirty_r <= {NREGS{1'b0}};
        end else begin
            if (wr_hit_s) begin
                regs_r[wr_addr] <= wr_data;
            end
            dirty_r <= (accept_s ? {NREGS{1'b0}} : dirty_r) | wr_mask_s;
        end
    end

    // Registered read ports (read-before-write, index 0 forced to zero)
    always_ff @(posedge clk12) begin
        if (rst) begin
            rd0_r <= {XLEN{1'b0}};
            rd1_r <= {XLEN{1'b0}};
        end else begin
            rd0_r <= (rd_addr0 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[rd_addr0];
            rd1_r <= (rd_addr1 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[rd_addr1];
        end
    end

    // Dump FSM state, output registers, counters and the dirty snapshot
    always_ff @(posedge clk12) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            reg_idx_r  <= {(AW+1){1'b0}};
            byte_idx_r <= {BW{1'b0}};
            shift_r    <= {XLEN{1'b0}};
            csum_r     <= 8'h00;
            snap_r     <= {NREGS{1'b0}};
            mode_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            tx_data_r  <= tx_data_nx;
            tx_valid_r <= tx_valid_nx;
            busy_r     <= busy_nx;
            reg_idx_r  <= reg_idx_nx;
            byte_idx_r <= byte_idx_nx;
            shift_r    <= shift_nx;
            csum_r     <= csum_nx;
            if (accept_s) begin
                snap_r <= dirty_r;
                mode_r <= dump_mode;
            end
        end
    end

    // Next-state and next-output logic; everything advances only on a byte transfer
    always_comb begin
        state_nx    = state_r;
        tx_data_nx  = tx_data_r;
        tx_valid_nx = tx_valid_r;
        busy_nx     = busy_r;
        reg_idx_nx  = reg_idx_r;
        byte_idx_nx = byte_idx_r;
        shift_nx    = shift_r;
        csum_nx     = csum_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dump_req) begin
                    accept_s    = 1'b1;
                    state_nx    = ST_HDR;
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = dump_mode ? HDR_DIRTY : HDR_ALL;
                    busy_nx     = 1'b1;
                    reg_idx_nx  = {(AW+1){1'b0}};
                    byte_idx_nx = {BW{1'b0}};
                    csum_nx     = 8'h00;
                end else begin
                    tx_valid_nx = 1'b0;
                    busy_nx     = 1'b0;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    csum_nx = csum_fold(csum_r, tx_data_r);
                    if (mode_r) begin
                        state_nx    = ST_SCAN;
                        tx_valid_nx = 1'b0;
                    end else begin
                        state_nx    = ST_DATA;
                        shift_nx    = cur_word_s;
                        tx_data_nx  = cur_word_s[7:0];
                        byte_idx_nx = ONE_B;
                    end
                end else begin
                    state_nx = ST_HDR;
                end
            end
            ST_SCAN: begin
                if (reg_idx_r == NREGS_C) begin
                    state_nx    = ST_TERM;
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = TERM_BYTE;
                end else if (snap_r[reg_idx_r[AW-1:0]]) begin
                    state_nx    = ST_IDX;
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = 8'(reg_idx_r);
                end else begin
                    reg_idx_nx = idx_inc_s;
                end
            end
            ST_IDX: begin
                if (xfer_s) begin
                    csum_nx     = csum_fold(csum_r, tx_data_r);
                    state_nx    = ST_DATA;
                    shift_nx    = cur_word_s;
                    tx_data_nx  = cur_word_s[7:0];
                    byte_idx_nx = ONE_B;
                end else begin
                    state_nx = ST_IDX;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    csum_nx = csum_fold(csum_r, tx_data_r);
                    if (byte_idx_r == NBYTES_C) begin
                        if (mode_r) begin
                            reg_idx_nx  = idx_inc_s;
                            state_nx    = ST_SCAN;
                            tx_valid_nx = 1'b0;
                        end else if (reg_idx_r == LAST_C) begin
                            state_nx   = ST_CSUM;
                            tx_data_nx = csum_nx;
                        end else begin
                            reg_idx_nx  = idx_inc_s;
                            shift_nx    = next_word_s;
                            tx_data_nx  = next_word_s[7:0];
                            byte_idx_nx = ONE_B;
                        end
                    end else begin
                        shift_nx    = shift_r >> 4'd8;
                        tx_data_nx  = shift_nx[7:0];
                        byte_idx_nx = byte_idx_r + ONE_B;
                    end
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_TERM: begin
                if (xfer_s) begin
                    csum_nx    = csum_fold(csum_r, tx_data_r);
                    state_nx   = ST_CSUM;
                    tx_data_nx = csum_nx;
                end else begin
                    state_nx = ST_TERM;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    state_nx    = ST_IDLE;
                    tx_valid_nx = 1'b0;
                    tx_data_nx  = 8'h00;
                    busy_nx     = 1'b0;
                end else begin
                    state_nx = ST_CSUM;
                end
            end
            default: begin
                state_nx    = ST_IDLE;
                tx_valid_nx = 1'b0;
                busy_nx     = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_regfile_uart_dumper.sv
// Scoreboard bench: a frame model pushes expected bytes at dump acceptance;
// a monitor pops and compares on every transfer and checks stall stability.
module tb_regfile_uart_dumper;
    localparam int XLEN  = 32;
    localparam int NREGS = 4;

    logic        clk12 = 1'b0;
    logic        rst = 1'b1, wr_en = 1'b0, dump_req = 1'b0, dump_mode = 1'b0, tx_ready = 1'b0;
    logic [1:0]  wr_addr = 2'd0, rd_addr0 = 2'd0, rd_addr1 = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data0, rd_data1;
    logic        busy, tx_valid;
    logic [7:0]  tx_data;

    int          tests = 0, fails = 0, n_xfer = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] m_regs[NREGS];
    bit          m_dirty[NREGS];
    bit          stall_prev = 1'b0;
    logic [7:0]  held = 8'h00;
    logic [7:0]  e_byte;

    always #5 clk12 = ~clk12;

    regfile_uart_dumper #(.XLEN(XLEN), .NREGS(NREGS), .HDR_ALL(8'hA5), .HDR_DIRTY(8'h5A)) dut (
        .clk12(clk12), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .dump_req(dump_req), .dump_mode(dump_mode), .busy(busy), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every transferred byte; a stalled byte must stay put
    initial begin
        forever begin
            @(negedge clk12);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", 64'(tx_valid), 64'd1);
                    chk("stall_data", 64'(tx_data), 64'(held));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_byte: got %0h, expected no byte", tx_data);
                    end else begin
                        e_byte = exp_q.pop_front();
                        chk("tx_byte", 64'(tx_data), 64'(e_byte));
                    end
                    n_xfer++;
                end
                stall_prev = tx_valid && !tx_ready;
                held = tx_data;
            end
        end
    end

    task automatic tick;
        @(posedge clk12);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 32'd0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick;
        wr_en = 1'b0;
        if (a != 2'd0) begin
            m_regs[a] = d;
            m_dirty[a] = 1'b1;
        end
    endtask

    task automatic check_read(input logic [1:0] a0, input logic [1:0] a1);
        rd_addr0 = a0; rd_addr1 = a1;
        tick;
        chk("rd_data0", 64'(rd_data0), 64'(m_regs[a0]));
        chk("rd_data1", 64'(rd_data1), 64'(m_regs[a1]));
    endtask

    // Expected frame straight from the frame rules: header, words LSB first, FF, XOR
    function automatic void build_frame(input bit mode);
        logic [7:0] fr[$];
        logic [7:0] c;
        c = 8'h00;
        fr.push_back(mode ? 8'h5A : 8'hA5);
        for (int i = 0; i < NREGS; i++) begin
            if (!mode || m_dirty[i]) begin
                if (mode) fr.push_back(8'(i));
                for (int b = 0; b < XLEN / 8; b++) fr.push_back(m_regs[i][8*b +: 8]);
            end
        end
        if (mode) fr.push_back(8'hFF);
        foreach (fr[k]) c = c ^ fr[k];
        fr.push_back(c);
        foreach (fr[k]) exp_q.push_back(fr[k]);
        for (int i = 0; i < NREGS; i++) m_dirty[i] = 1'b0;
    endfunction

    task automatic start_dump(input bit mode, input bit wr, input logic [1:0] wa, input logic [31:0] wd);
        build_frame(mode);
        dump_req = 1'b1; dump_mode = mode;
        if (wr) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        end
        tick;
        dump_req = 1'b0; wr_en = 1'b0;
        if (wr && wa != 2'd0) begin
            m_regs[wa] = wd;
            m_dirty[wa] = 1'b1;
        end
        chk("busy_on_accept", 64'(busy), 64'd1);
        chk("hdr_valid", 64'(tx_valid), 64'd1);
        chk("hdr_byte", 64'(tx_data), mode ? 64'h5A : 64'hA5);
    endtask

    task automatic run_frame(input bit rnd_ready, input bit noise);
        int cyc;
        cyc = 0;
        while (busy && cyc < 3000) begin
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            dump_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            dump_mode = 1'($urandom_range(0, 1));
            tick;
            cyc++;
        end
        dump_req = 1'b0;
        chk("frame_timeout", 64'(cyc < 3000), 64'd1);
        chk("frame_leftover", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_xfers(input int target);
        int cyc;
        cyc = 0;
        while (n_xfer < target && cyc < 200) begin
            tick;
            cyc++;
        end
        chk("xfer_wait_timeout", 64'(cyc < 200), 64'd1);
    endtask

    initial begin
        int nw, base;
        model_clear();
        // reset wins over a concurrent write and dump request
        rst = 1'b1; dump_req = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hFFFF_FFFF;
        tick; tick;
        rst = 1'b0; dump_req = 1'b0; wr_en = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data", 64'(tx_data), 64'd0);
        chk("rst_rd0", 64'(rd_data0), 64'd0);
        check_read(2'd2, 2'd1);

        // full dump of two written registers
        tx_ready = 1'b1;
        do_write(2'd1, 32'h1122_3344);
        do_write(2'd3, 32'hDEAD_BEEF);
        start_dump(1'b0, 1'b0, 2'd0, 32'd0);
        run_frame(1'b0, 1'b0);

        // dirty dump of the same writes, then an immediate empty one
        do_write(2'd1, 32'h1122_3344);
        do_write(2'd3, 32'hDEAD_BEEF);
        start_dump(1'b1, 1'b0, 2'd0, 32'd0);
        run_frame(1'b0, 1'b0);
        start_dump(1'b1, 1'b0, 2'd0, 32'd0);
        run_frame(1'b0, 1'b0);

        // register 0 is hardwired and never dirty
        do_write(2'd0, 32'hFFFF_FFFF);
        check_read(2'd0, 2'd3);
        start_dump(1'b1, 1'b0, 2'd0, 32'd0);
        run_frame(1'b0, 1'b0);

        // read-before-write on the same index
        rd_addr0 = 2'd3; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'h0BAD_F00D;
        tick;
        wr_en = 1'b0;
        chk("rbw_old", 64'(rd_data0), 64'hDEAD_BEEF);
        m_regs[3] = 32'h0BAD_F00D; m_dirty[3] = 1'b1;
        check_read(2'd3, 2'd1);
        start_dump(1'b0, 1'b0, 2'd0, 32'd0);
        run_frame(1'b1, 1'b0);

        // write in the accept cycle stays dirty for the next dump
        start_dump(1'b1, 1'b1, 2'd2, 32'hA1B2_C3D4);
        run_frame(1'b0, 1'b0);
        start_dump(1'b1, 1'b0, 2'd0, 32'd0);
        run_frame(1'b0, 1'b0);

        // stall mid-register and overwrite it: captured word goes out unchanged
        do_write(2'd1, 32'hCAFE_F00D);
        tx_ready = 1'b1;
        base = n_xfer;
        start_dump(1'b1, 1'b0, 2'd0, 32'd0);
        wait_xfers(base + 3);
        tx_ready = 1'b0;
        chk("stall_byte", 64'(tx_data), 64'hF0);
        do_write(2'd1, 32'h1234_5678);
        repeat (4) tick;
        chk("stall_byte_after", 64'(tx_data), 64'hF0);
        run_frame(1'b0, 1'b0);
        start_dump(1'b1, 1'b0, 2'd0, 32'd0);
        run_frame(1'b0, 1'b0);

        // dump requests while busy are ignored
        start_dump(1'b0, 1'b0, 2'd0, 32'd0);
        run_frame(1'b1, 1'b1);

        // randomized writes, reads and dumps
        for (int it = 0; it < 25; it++) begin
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++) do_write(2'($urandom_range(0, 3)), $urandom);
            check_read(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            start_dump(1'($urandom_range(0, 1)), 1'b0, 2'd0, 32'd0);
            run_frame(1'b1, 1'($urandom_range(0, 1)));
        end

        // reset after three transferred bytes aborts the frame
        do_write(2'd2, 32'h5555_AAAA);
        tx_ready = 1'b1;
        base = n_xfer;
        start_dump(1'b0, 1'b0, 2'd0, 32'd0);
        wait_xfers(base + 3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        chk("abort_valid", 64'(tx_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (3) begin
            tick;
            chk("abort_quiet", 64'(tx_valid), 64'd0);
        end
        check_read(2'd1, 2'd2);
        check_read(2'd3, 2'd0);
        start_dump(1'b1, 1'b0, 2'd0, 32'd0);
        run_frame(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
